// File: rtl/call_stack_pkg.sv
// Shared types and sizing for the call/return stack sequencer.
package call_stack_pkg;

    localparam int STACK_DEPTH = 32;
    localparam int CAPACITY    = STACK_DEPTH - 1;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

    typedef enum logic [1:0] {
        OP_PUSH8 = 2'b00,
        OP_POP8  = 2'b01,
        OP_CALL  = 2'b10,
        OP_RET   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_LO,
        PUSH_HI,
        POP_HI,
        POP_LO,
        CAP_LO,
        RESP
    } state_t;

    // True when the command fits in (push) or is available from (pop) the stack.
    function automatic logic cmd_ok(input op_t op, input logic [DEPTH_W-1:0] depth);
        logic [DEPTH_W-1:0] cap;
        cap = DEPTH_W'(CAPACITY);
        case (op)
            OP_PUSH8: cmd_ok = (depth <= cap - DEPTH_W'(1));
            OP_CALL:  cmd_ok = (depth <= cap - DEPTH_W'(2));
            OP_POP8:  cmd_ok = (depth >= DEPTH_W'(1));
            default:  cmd_ok = (depth >= DEPTH_W'(2));
        endcase
    endfunction

endpackage

// File: rtl/call_stack_ctrl.sv
// Turns PUSH8/POP8/CALL/RET commands into single-cycle byte-stack strobes, splitting and rebuilding 16-bit addresses.
// Latency accept->rsp_valid: 2 PUSH8, 3 CALL/POP8, 4 RET, 1 on error; cmd_ready only in IDLE, no response back-pressure.
module call_stack_ctrl
    import call_stack_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [7:0]          cmd_data,
    input  logic [15:0]         cmd_pc,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [15:0]         rsp_data,
    output logic [DEPTH_W-1:0]  depth,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [7:0]          stk_din,
    input  logic [7:0]          stk_dout
);

    state_t      state, state_nxt;
    op_t         op_q;
    logic        wide_q;
    logic [15:0] data_buf;
    logic        accept;
    logic        ok;
    op_t         op_in;

    assign op_in  = op_t'(cmd_op);
    assign accept = cmd_valid && (state == IDLE);
    assign ok     = cmd_ok(op_in, depth);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_PUSH8;
            wide_q   <= 1'b0;
            data_buf <= 16'h0000;
            rsp_err  <= 1'b0;
            depth    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q     <= op_in;
                wide_q   <= cmd_op[1];
                data_buf <= (op_in == OP_PUSH8) ? {8'h00, cmd_data} : cmd_pc;
                rsp_err  <= !ok;
                if (ok) begin
                    case (op_in)
                        OP_PUSH8: depth <= depth + DEPTH_W'(1);
                        OP_CALL:  depth <= depth + DEPTH_W'(2);
                        OP_POP8:  depth <= depth - DEPTH_W'(1);
                        default:  depth <= depth - DEPTH_W'(2);
                    endcase
                end
            end
            // Stack output lags its pop strobe by one cycle.
            if (state == POP_LO) data_buf[15:8] <= stk_dout;
            if (state == CAP_LO) data_buf[7:0]  <= stk_dout;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_din   = 8'h00;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    if (!ok)                   state_nxt = RESP;
                    else if (op_in == OP_POP8) state_nxt = POP_LO;
                    else if (op_in == OP_RET)  state_nxt = POP_HI;
                    else                       state_nxt = PUSH_LO;
                end
            end
            PUSH_LO: begin
                stk_push  = 1'b1;
                stk_din   = data_buf[7:0];
                state_nxt = wide_q ? PUSH_HI : RESP;
            end
            PUSH_HI: begin
                stk_push  = 1'b1;
                stk_din   = data_buf[15:8];
                state_nxt = RESP;
            end
            POP_HI: begin
                stk_pop   = 1'b1;
                state_nxt = POP_LO;
            end
            POP_LO: begin
                stk_pop   = 1'b1;
                state_nxt = CAP_LO;
            end
            CAP_LO:  state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only successful POP8/RET carry data; everything else reports zero.
    always_comb begin
        rsp_data = 16'h0000;
        if (!rsp_err && op_q[0])
            rsp_data = wide_q ? data_buf : {8'h00, data_buf[7:0]};
    end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Randomized scoreboard bench for call_stack_ctrl driving a behavioural 32-byte stack.
module tb_call_stack_ctrl;
    import call_stack_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_data = 8'h00;
    logic [15:0] cmd_pc = 16'h0000;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_data;
    logic [DEPTH_W-1:0] depth;
    logic        stk_push, stk_pop;
    logic [7:0]  stk_din;
    logic [7:0]  stk_dout;

    call_stack_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_pc(cmd_pc),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .depth(depth), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_din(stk_din), .stk_dout(stk_dout)
    );

    always #5 clk = ~clk;

    // Byte stack downstream of the controller.
    logic [7:0] mem [STACK_DEPTH];
    int         sp;
    int         n_push_seen, n_pop_seen;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            sp <= 0;
            stk_dout <= 8'h00;
            n_push_seen <= 0;
            n_pop_seen <= 0;
        end else if (stk_push) begin
            mem[sp % STACK_DEPTH] <= stk_din;
            sp <= sp + 1;
            n_push_seen <= n_push_seen + 1;
        end else if (stk_pop) begin
            stk_dout <= mem[(sp + STACK_DEPTH - 1) % STACK_DEPTH];
            sp <= sp - 1;
            n_pop_seen <= n_pop_seen + 1;
        end
    end

    typedef struct {
        logic        err;
        logic [15:0] data;
        int          dep;
        int          lat;
        int          acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model[$];
    int         exp_push, exp_pop;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain byte queue, command outcome from capacity rules.
    task automatic predict(input logic [1:0] op, input logic [7:0] d, input logic [15:0] pc);
        exp_t e;
        int n;
        n = model.size();
        e.err = 1'b0;
        e.data = 16'h0000;
        e.acc = cyc + 1;
        case (op)
            2'b00: if (n + 1 <= CAPACITY) begin
                       model.push_back(d); exp_push += 1; e.lat = 2;
                   end else e.err = 1'b1;
            2'b10: if (n + 2 <= CAPACITY) begin
                       model.push_back(pc[7:0]); model.push_back(pc[15:8]);
                       exp_push += 2; e.lat = 3;
                   end else e.err = 1'b1;
            2'b01: if (n >= 1) begin
                       e.data = {8'h00, model.pop_back()}; exp_pop += 1; e.lat = 3;
                   end else e.err = 1'b1;
            default: if (n >= 2) begin
                       e.data[15:8] = model.pop_back();
                       e.data[7:0]  = model.pop_back();
                       exp_pop += 2; e.lat = 4;
                   end else e.err = 1'b1;
        endcase
        if (e.err) e.lat = 1;
        e.dep = model.size();
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [15:0] pc, input bit hold);
        int w;
        w = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_pc = pc;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(w), 32'd0);
            cmd_valid = 1'b0;
        end else begin
            predict(op, d, pc);
            @(posedge clk);
            #1;
            if (!hold) cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete(); model.delete();
        exp_push = 0; exp_pop = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            chk("strobe_excl", 32'(stk_push & stk_pop), 32'd0);
            chk("ready_busy", 32'(cmd_ready),
                32'(!(sb.size() > 0 && sb[0].acc <= cyc)));
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("depth", 32'(depth), 32'(e.dep));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat - 1));
                end
            end
        end
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
        chk("rst_din", 32'(stk_din), 32'd0);

        // CALL then RET round-trips the address
        issue(2'b10, 8'h00, 16'hA53C, 0);
        drain();
        chk("call_lo_byte", 32'(mem[0]), 32'h3C);
        chk("call_hi_byte", 32'(mem[1]), 32'hA5);
        issue(2'b11, 8'h00, 16'h0000, 0);
        drain();

        // LIFO order of single bytes
        issue(2'b00, 8'h11, 16'h0, 0);
        issue(2'b00, 8'h22, 16'h0, 0);
        issue(2'b00, 8'h33, 16'h0, 0);
        repeat (3) issue(2'b01, 8'h00, 16'h0, 0);
        drain();

        // RET underflow at depth 1, byte still retrievable
        issue(2'b00, 8'h7F, 16'h0, 0);
        issue(2'b11, 8'h00, 16'h0, 0);
        drain();
        chk("underflow_no_pop", 32'(n_pop_seen), 32'(exp_pop));
        issue(2'b01, 8'h00, 16'h0, 0);
        drain();

        // Fill to capacity, overflow on PUSH8 and on CALL at depth 30
        for (int i = 0; i < CAPACITY; i++) issue(2'b00, 8'($urandom), 16'h0, 0);
        issue(2'b00, 8'hEE, 16'h0, 0);
        issue(2'b01, 8'h00, 16'h0, 0);
        issue(2'b10, 8'h00, 16'h1234, 0);
        issue(2'b01, 8'h00, 16'h0, 0);
        drain();

        // Random traffic
        for (int i = 0; i < 250; i++)
            issue(2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom), 0);
        drain();
        chk("push_count", 32'(n_push_seen), 32'(exp_push));
        chk("pop_count", 32'(n_pop_seen), 32'(exp_pop));

        // Back-to-back CALL/RET with cmd_valid held high
        do_reset();
        for (int i = 0; i < 10; i++)
            issue((i % 2 == 0) ? 2'b10 : 2'b11, 8'h00, 16'($urandom), (i != 9));
        drain();

        // Reset during POP_LO of a RET
        issue(2'b10, 8'h00, 16'hBEEF, 0);
        drain();
        issue(2'b11, 8'h00, 16'h0, 0);
        @(negedge clk);
        chk("pop_hi_strobe", 32'(stk_pop), 32'd1);
        @(negedge clk);
        chk("pop_lo_strobe", 32'(stk_pop), 32'd1);
        rst = 1'b1;
        sb.delete(); model.delete();
        exp_push = 0; exp_pop = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
        chk("midrst_depth", 32'(depth), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        repeat (5) @(negedge clk);

        // Command coincident with reset is dropped
        issue(2'b00, 8'h5A, 16'h0, 0);
        drain();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'hC3;
        sb.delete(); model.delete();
        exp_push = 0; exp_pop = 0;
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        chk("rstcmd_depth", 32'(depth), 32'd0);
        chk("rstcmd_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
        repeat (4) @(negedge clk);
        chk("rstcmd_depth_late", 32'(depth), 32'd0);
        issue(2'b01, 8'h00, 16'h0, 0);
        drain();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
